step_sequencer: RTL

Microstep sequencer on the consuming side of the CPU clock. It turns the CPU clock level into single-cycle step ticks in the `system_clock` domain and advances the T-state counter that indexes microcode. It latches the HLT control bit and returns the `halt` run-enable to the clock generator, where 1 means run and 0 means stopped. It sits between the clock generator and the microcode ROM/control decode.

---
 rtl/eater_pkg.sv | 17 +
 rtl/edge_sync.sv | 28 ++
 rtl/step_sequencer.sv | 68 ++++++
 3 files changed

// File: rtl/eater_pkg.sv
// Shared constants and the microstep type for the sequencer and its decode.
package eater_pkg;

    localparam int STEPS_DEFAULT = 5;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6,
        T7 = 3'd7
    } step_t;

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module edge_sync (
    input  logic system_clock,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s1 may be metastable; the edge is judged only on settled s2/s3
    assign rise = s2 & ~s3;

endmodule

// File: rtl/step_sequencer.sv
// Microstep sequencer: CPU clock edges become step ticks that advance the T-state,
// retire instructions, and latch HLT into the run-enable returned to the clock generator.
module step_sequencer
    import eater_pkg::*;
#(
    parameter int STEPS  = STEPS_DEFAULT,
    parameter int STEP_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              system_clock,
    input  logic              reset_n,
    input  logic              cpu_clock,
    input  logic              hlt,
    input  logic              end_instr,
    input  logic              resume,
    output logic              halt,
    output logic [STEP_W-1:0] step,
    output logic [STEPS-1:0]  step_onehot,
    output logic              tick,
    output logic              instr_done,
    output logic [CNT_W-1:0]  instr_count
);

    logic cpu_edge;
    logic retire;

    edge_sync u_edge_sync (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .async_in     (cpu_clock),
        .rise         (cpu_edge)
    );

    // Edges seen while halted are dropped, not queued
    assign tick = cpu_edge & halt;

    // Fetch (T0/T1) always completes, so early termination counts only from T2
    assign retire = (step == STEP_W'(STEPS - 1)) ||
                    (end_instr && (step >= STEP_W'(T2)));

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            halt        <= 1'b1;
            step        <= STEP_W'(T0);
            instr_done  <= 1'b0;
            instr_count <= '0;
        end else begin
            instr_done <= 1'b0;
            if (tick) begin
                if (hlt) begin
                    // The HLT step is held, so a halting tick always beats a resume
                    halt <= 1'b0;
                end else if (retire) begin
                    step        <= STEP_W'(T0);
                    instr_done  <= 1'b1;
                    instr_count <= instr_count + CNT_W'(1);
                end else begin
                    step <= step + STEP_W'(1);
                end
            end else if (resume) begin
                halt <= 1'b1;
            end
        end
    end

    assign step_onehot = STEPS'(1) << step;

endmodule
